// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and handshake constants.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package iter_divider_pkg;

    // Divider control FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    // Level of start_i that requests a new division
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Level of ready_o when result_o carries a fresh result
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Annul request level
    localparam logic DivAnnul          = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: resolves a single quotient bit.
// Latency: purely combinational, chained STEP times per iteration cycle.
// Backpressure: none; the caller decides when the outputs are captured.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    // Partial remainder shifted left with the next dividend bit; one extra
    // bit so a divisor with its MSB set still compares correctly.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_i};

    // Since rem_i < dvsr_i, a non-negative difference always fits in WIDTH
    // bits and a borrow always lands in the top bit.
    assign fits    = ~diff[WIDTH];

    // Restore on borrow, otherwise keep the difference and record a 1
    always_comb begin
        rem_o  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_o = {quot_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider producing {remainder, quotient}, STEP quotient bits per cycle.
// Latency: ready_o pulses WIDTH/STEP+2 cycles after start (2 cycles for a zero divisor).
// Backpressure: start_i ignored while busy_o or in the result cycle; annul_i aborts a running divide.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = $clog2(N + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               quot_neg_q, quot_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dbz_q, dbz_d;

    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic               dvsr_is_zero;
    logic               last_iter;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH-1:0]   rem_chain  [STEP+1];
    logic [WIDTH-1:0]   quot_chain [STEP+1];

    // Operand magnitudes; the most-negative value maps to itself, which read
    // as unsigned is exactly its magnitude.
    always_comb begin
        op1_neg      = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg      = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag      = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag      = op2_neg ? -opdata2_i : opdata2_i;
        dvsr_is_zero = (opdata2_i == '0);
    end

    // After N iterations the counter parks at N for the sign-fixup cycle
    assign last_iter = (cnt_q == CNT_W'(N));

    // Sign restoration: quotient negative when signs differ, remainder follows dividend
    always_comb begin
        quot_fix = quot_neg_q ? -quot_q : quot_q;
        rem_fix  = rem_neg_q  ? -rem_q  : rem_q;
    end

    assign rem_chain[0]  = rem_q;
    assign quot_chain[0] = quot_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        div_step #(
            .WIDTH (WIDTH)
        ) u_div_step (
            .rem_i  (rem_chain[g]),
            .quot_i (quot_chain[g]),
            .dvsr_i (dvsr_q),
            .rem_o  (rem_chain[g+1]),
            .quot_o (quot_chain[g+1])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        ready_o = DivResultNotReady;
        case (state_q)
            DIV_IDLE: begin
                if (start_i == DivStart) begin
                    state_d = dvsr_is_zero ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                busy_o  = 1'b1;
                state_d = (annul_i == DivAnnul) ? DIV_IDLE : DIV_END;
            end
            DIV_ON: begin
                busy_o = 1'b1;
                if (annul_i == DivAnnul) begin
                    state_d = DIV_IDLE;
                end else if (last_iter) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                ready_o = DivResultReady;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // Datapath next state: latch on accept, iterate in ON, publish result on entry to END
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i == DivStart) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    quot_d     = op1_mag;
                    dvsr_d     = op2_mag;
                    quot_neg_d = op1_neg ^ op2_neg;
                    rem_neg_d  = op1_neg;
                end
            end
            DIV_ZERO: begin
                if (annul_i != DivAnnul) begin
                    result_d = '0;
                    dbz_d    = 1'b1;
                end
            end
            DIV_ON: begin
                if (annul_i != DivAnnul) begin
                    if (last_iter) begin
                        result_d = {rem_fix, quot_fix};
                        dbz_d    = 1'b0;
                    end else begin
                        rem_d  = rem_chain[STEP];
                        quot_d = quot_chain[STEP];
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            dbz_q      <= dbz_d;
        end
    end

    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: STEP=1 and STEP=2 instances against an arithmetic reference model.
// Latency: checks exact ready_o cycle for every operation.
// Backpressure: exercises start while busy, start/annul in the result cycle, annul and reset mid-run.
module tb_iter_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn  [2];
    logic           start   [2];
    logic           sdiv    [2];
    logic           annul   [2];
    logic [W-1:0]   op1     [2];
    logic [W-1:0]   op2     [2];
    logic           busy    [2];
    logic           ready   [2];
    logic           dbz     [2];
    logic [2*W-1:0] res     [2];

    iter_divider #(.WIDTH(W), .STEP(1)) u_dut_s1 (
        .clk           (clk),
        .resetn        (resetn[0]),
        .start_i       (start[0]),
        .signed_div_i  (sdiv[0]),
        .opdata1_i     (op1[0]),
        .opdata2_i     (op2[0]),
        .annul_i       (annul[0]),
        .busy_o        (busy[0]),
        .ready_o       (ready[0]),
        .result_o      (res[0]),
        .div_by_zero_o (dbz[0])
    );

    iter_divider #(.WIDTH(W), .STEP(2)) u_dut_s2 (
        .clk           (clk),
        .resetn        (resetn[1]),
        .start_i       (start[1]),
        .signed_div_i  (sdiv[1]),
        .opdata1_i     (op1[1]),
        .opdata2_i     (op2[1]),
        .annul_i       (annul[1]),
        .busy_o        (busy[1]),
        .ready_o       (ready[1]),
        .result_o      (res[1]),
        .div_by_zero_o (dbz[1])
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; returns {div_by_zero, remainder, quotient}
    function automatic logic [64:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 0) return {1'b1, 64'd0};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {1'b0, ur, uq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation on DUT d from IDLE and check latency, busy, result and flag.
    // poke: also pulse start mid-run, and start+annul during the result cycle.
    task automatic run_op(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit poke);
        logic [64:0]   e;
        logic [2*W-1:0] held;
        int lat, cyc, busy_bad;
        e   = model(sgn, a, b);
        lat = (b == 0) ? 2 : ((d == 0) ? 34 : 18);
        start[d] = 1'b1; sdiv[d] = sgn; op1[d] = a; op2[d] = b;
        tick();
        start[d] = 1'b0;
        sdiv[d]  = 1'($urandom_range(0, 1));
        op1[d]   = $urandom;
        op2[d]   = $urandom;
        cyc = 1;
        busy_bad = 0;
        while (ready[d] !== 1'b1 && cyc < 100) begin
            if (busy[d] !== 1'b1) busy_bad++;
            start[d] = (poke && cyc == 5) ? 1'b1 : 1'b0;
            tick();
            start[d] = 1'b0;
            cyc++;
        end
        check({tag, "/latency"}, cyc, lat);
        check({tag, "/busy_during"}, busy_bad, 0);
        check({tag, "/busy_in_end"}, busy[d], 1'b0);
        check({tag, "/result"}, res[d], e[63:0]);
        check({tag, "/dbz"}, dbz[d], e[64]);
        held = res[d];
        if (poke) begin
            start[d] = 1'b1; annul[d] = 1'b1; op2[d] = 32'd3;
        end
        tick();
        start[d] = 1'b0; annul[d] = 1'b0;
        check({tag, "/ready_one_cycle"}, ready[d], 1'b0);
        check({tag, "/idle_after_end"}, busy[d], 1'b0);
        if (poke) begin
            tick();
            check({tag, "/start_in_end_ignored"}, busy[d], 1'b0);
            check({tag, "/result_held"}, res[d], held);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        int          seen;

        for (int i = 0; i < 2; i++) begin
            resetn[i] = 1'b0; start[i] = 1'b0; sdiv[i] = 1'b0; annul[i] = 1'b0;
            op1[i] = '0; op2[i] = '0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            check("reset/busy",   busy[i],  1'b0);
            check("reset/ready",  ready[i], 1'b0);
            check("reset/result", res[i],   64'd0);
            check("reset/dbz",    dbz[i],   1'b0);
        end
        tick(); tick();
        resetn[0] = 1'b1; resetn[1] = 1'b1;
        tick();

        // Directed cases, STEP=1
        run_op(0, 1'b0, 32'd100, 32'd7, "u100/7", 1'b0);
        run_op(0, 1'b1, -32'sd7, 32'd2, "s-7/2", 1'b0);
        run_op(0, 1'b1, 32'd7, -32'sd2, "s7/-2", 1'b0);
        check("s7/-2/quot_literal", res[0][31:0], 32'hFFFFFFFD);
        run_op(0, 1'b0, 32'd5, 32'd0, "u5/0", 1'b0);
        run_op(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, "smin/-1", 1'b0);
        check("smin/-1/literal", res[0], {32'd0, 32'h80000000});
        run_op(0, 1'b0, 32'h80000000, 32'hFFFFFFFF, "umin/max", 1'b0);
        check("umin/max/literal", res[0], {32'h80000000, 32'd0});
        run_op(0, 1'b0, 32'd1000, 32'd9, "poke", 1'b1);

        // Annul during iteration 10, then an immediate new start
        run_op(0, 1'b0, 32'd100, 32'd7, "pre_annul", 1'b0);
        start[0] = 1'b1; sdiv[0] = 1'b0; op1[0] = 32'd12345; op2[0] = 32'd11;
        tick();
        start[0] = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        annul[0] = 1'b1;
        tick();
        annul[0] = 1'b0;
        check("annul/busy",   busy[0],  1'b0);
        check("annul/ready",  ready[0], 1'b0);
        check("annul/result", res[0],   {32'd2, 32'd14});
        run_op(0, 1'b0, 32'd9, 32'd3, "post_annul9/3", 1'b0);
        check("post_annul9/3/literal", res[0], {32'd0, 32'd3});

        // Annul in the divide-by-zero cycle
        start[0] = 1'b1; op1[0] = 32'd5; op2[0] = 32'd0;
        tick();
        start[0] = 1'b0; annul[0] = 1'b1;
        tick();
        annul[0] = 1'b0;
        check("annul_dz/busy", busy[0], 1'b0);
        check("annul_dz/dbz",  dbz[0],  1'b0);
        check("annul_dz/result", res[0], {32'd0, 32'd3});
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ready[0] === 1'b1) seen++;
            tick();
        end
        check("annul_dz/no_ready", seen, 0);

        // Random operations on both step sizes
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_op(i % 2, sgn, a, b, (i % 2 == 0) ? "rand_s1" : "rand_s2", 1'($urandom_range(0, 1)));
        end

        // STEP=2 directed, then reset mid-operation
        run_op(1, 1'b0, 32'd100, 32'd7, "s2_u100/7", 1'b0);
        check("s2_u100/7/literal", res[1], {32'd2, 32'd14});
        start[1] = 1'b1; op1[1] = 32'd999; op2[1] = 32'd4;
        tick();
        start[1] = 1'b0;
        tick(); tick(); tick();
        resetn[1] = 1'b0;
        #1;
        check("rst_mid/busy",   busy[1],  1'b0);
        check("rst_mid/ready",  ready[1], 1'b0);
        check("rst_mid/result", res[1],   64'd0);
        check("rst_mid/dbz",    dbz[1],   1'b0);
        tick();
        resetn[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            if (ready[1] === 1'b1 || busy[1] === 1'b1) seen++;
            tick();
        end
        check("rst_mid/no_activity", seen, 0);
        run_op(1, 1'b1, -32'sd7, 32'd2, "s2_after_rst", 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required completion");
        $fatal(1, "timeout");
    end

endmodule
